// File: rtl/seg_display_driver.sv
// Drives a 4-digit multiplexed seven-segment display from an 8-bit port value,
// shown as two hex digits or as unsigned decimal via a sequential double-dabble engine.
module seg_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       dec_mode,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] TERM_COUNT = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [8:0]      last_snap;
    logic [8:0]      snap;
    logic [19:0]     sreg;
    logic [2:0]      iter;
    logic [3:0][3:0] digits;
    logic [3:0]      blank;
    logic [3:0][3:0] commit_digits;
    logic [3:0]      commit_blank;
    logic            input_changed;
    logic [CW-1:0]   refresh_cnt;
    logic [1:0]      idx;

    // One double-dabble step: correct every BCD nibble that would overflow, then shift.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5)
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'h0: seg_code = 7'b1000000;
            4'h1: seg_code = 7'b1111001;
            4'h2: seg_code = 7'b0100100;
            4'h3: seg_code = 7'b0110000;
            4'h4: seg_code = 7'b0011001;
            4'h5: seg_code = 7'b0010010;
            4'h6: seg_code = 7'b0000010;
            4'h7: seg_code = 7'b1111000;
            4'h8: seg_code = 7'b0000000;
            4'h9: seg_code = 7'b0010000;
            4'hA: seg_code = 7'b0001000;
            4'hB: seg_code = 7'b0000011;
            4'hC: seg_code = 7'b1000110;
            4'hD: seg_code = 7'b0100001;
            4'hE: seg_code = 7'b0000110;
            default: seg_code = 7'b0001110;
        endcase
    endfunction

    assign input_changed = ({value, dec_mode} != last_snap);
    assign busy          = (state != IDLE);
    assign dp            = 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (input_changed) state_next = SHIFT;
            SHIFT:   if (iter == 3'd7)  state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Digits and blank mask as they will be latched in COMMIT; snap[0] is the mode bit.
    always_comb begin
        commit_digits = '0;
        commit_blank  = 4'b1100;
        if (snap[0]) begin
            commit_digits[2] = sreg[19:16];
            commit_digits[1] = sreg[15:12];
            commit_digits[0] = sreg[11:8];
            commit_blank     = {1'b1, sreg[19:16] == 4'd0,
                                (sreg[19:16] == 4'd0) && (sreg[15:12] == 4'd0), 1'b0};
        end else begin
            commit_digits[1] = snap[8:5];
            commit_digits[0] = snap[4:1];
        end
    end

    // NOTE: the committed digit registers are reset too, so the display shows a defined "00" out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_snap <= '0;
            snap      <= '0;
            sreg      <= '0;
            iter      <= '0;
            digits    <= '0;
            blank     <= 4'b1100;
        end else begin
            case (state)
                IDLE: if (input_changed) begin
                    snap <= {value, dec_mode};
                    sreg <= {12'b0, value};
                    iter <= '0;
                end
                SHIFT: begin
                    sreg <= dabble_step(sreg);
                    iter <= iter + 3'd1;
                end
                COMMIT: begin
                    digits    <= commit_digits;
                    blank     <= commit_blank;
                    last_snap <= snap;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == TERM_COUNT) begin
            refresh_cnt <= '0;
            idx         <= idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Outputs are registered from the current slot, so they trail an index change by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else if (blank[idx]) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_code(digits[idx]);
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver: expected displays are queued on input
// changes and checked by a negedge monitor that follows commits and scans.
module tb_seg_display_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] value = 8'h00;
    logic       dec_mode = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    seg_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .dec_mode (dec_mode),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  lit;
    } disp_t;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int    n_checks = 0;
    int    n_fail   = 0;
    disp_t exp_q[$];
    logic [8:0] last_pair = 9'h000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what the display should show for a value/mode, from plain arithmetic.
    function automatic disp_t model(input int v, input bit dm);
        disp_t d;
        int h, t, u;
        if (dm) begin
            h = v / 100;
            t = (v / 10) % 10;
            u = v % 10;
            d.digits = {4'd0, 4'(h), 4'(t), 4'(u)};
            d.lit    = {1'b0, h != 0, (h != 0) || (t != 0), 1'b1};
        end else begin
            d.digits = {8'd0, 8'(v)};
            d.lit    = 4'b0011;
        end
        return d;
    endfunction

    task automatic note_change();
        if ({value, dec_mode} != last_pair) begin
            exp_q.push_back(model(int'(value), dec_mode));
            last_pair = {value, dec_mode};
        end
    endtask

    task automatic apply(input logic [7:0] v, input logic dm);
        @(negedge clk);
        value    = v;
        dec_mode = dm;
        note_change();
    endtask

    task automatic wait_commits(input int n);
        int  seen = 0;
        bit  was  = 0;
        for (int i = 0; i < 60 * n && seen < n; i++) begin
            @(negedge clk);
            if (was && !busy) seen++;
            was = busy;
        end
        check("commit_wait", seen, n);
    endtask

    // Monitor: checks every sample against the current expected display and
    // swaps in the next queued expectation whenever busy falls (a commit).
    disp_t      cur;
    int         busy_len;
    int         frame_n;
    int         found;
    logic [3:0] lit_seen;
    bit         prev_busy;

    always @(negedge clk) begin
        if (rst) begin
            cur = model(0, 0);
            exp_q.delete();
            busy_len  = 0;
            frame_n   = 0;
            lit_seen  = '0;
            prev_busy = 0;
            check("busy_in_reset", busy, 0);
        end else begin
            found = -1;
            for (int k = 0; k < 4; k++)
                if (an == ~(4'b0001 << k)) found = k;
            if (found >= 0) begin
                check("slot_lit", cur.lit[found], 1);
                check("seg_slot", seg, seg_tab[cur.digits[4*found +: 4]]);
                lit_seen[found] = 1'b1;
            end else begin
                check("an_blank", an, 4'hF);
                check("seg_blank", seg, 7'h7F);
            end
            check("dp_off", dp, 1);
            frame_n++;
            if (frame_n == 4 * DIV) begin
                check("frame_lit", lit_seen, cur.lit);
                frame_n  = 0;
                lit_seen = '0;
            end
            if (busy) busy_len++;
            if (prev_busy && !busy) begin
                check("busy_len", busy_len, 9);
                busy_len = 0;
                check("commit_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur      = exp_q.pop_front();
                    frame_n  = 0;
                    lit_seen = '0;
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        logic [3:0] an_exp;

        // Reset and idle scan of "00"
        repeat (2) @(negedge clk);
        check("reset_an", an, 4'b1110);
        check("reset_seg", seg, 7'b1000000);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            an_exp = (i < 4) ? 4'b1110 : (i < 8) ? 4'b1101 : 4'b1111;
            check("scan_an", an, an_exp);
            check("scan_busy", busy, 0);
        end

        // Hex A5, decimal 255, decimal 7
        apply(8'hA5, 1'b0);
        wait_commits(1);
        repeat (20) @(negedge clk);
        apply(8'd255, 1'b1);
        wait_commits(1);
        repeat (20) @(negedge clk);
        apply(8'd7, 1'b1);
        wait_commits(1);
        repeat (20) @(negedge clk);

        // Change mid-conversion: 200 commits, then 13 converts afterwards
        apply(8'd200, 1'b1);
        repeat (3) @(negedge clk);
        apply(8'd13, 1'b1);
        wait_commits(2);
        repeat (20) @(negedge clk);

        // Reset in the middle of converting 99
        apply(8'd99, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_an", an, 4'b1110);
        check("abort_seg", seg, 7'b1000000);
        last_pair = 9'h000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        note_change();
        @(posedge clk);
        #1 check("restart_busy", busy, 1);
        wait_commits(1);
        repeat (4) @(negedge clk);

        // Unchanged input never retriggers
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy) hi++;
        end
        check("idle_hold_busy", hi, 0);

        // Randomized values and modes
        for (int r = 0; r < 14; r++) begin
            logic [7:0] v;
            logic       dm;
            bit         changes;
            v  = 8'($urandom_range(0, 255));
            dm = 1'($urandom_range(0, 1));
            changes = ({v, dm} != last_pair);
            apply(v, dm);
            if (changes) wait_commits(1);
            repeat (20) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
